// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S stereo transceiver: default sample width,
// frame length and the frame-lock state encoding.
package i2s_pkg;

  localparam int DATA_W_DEFAULT = 24;
  localparam int FRAME_BITS     = 2 * DATA_W_DEFAULT;

  typedef enum logic {
    UNLOCKED = 1'b0,
    RUN      = 1'b1
  } lock_state_t;

  function automatic int frame_bits(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/i2s_stereo_transceiver_if.sv
// Sample-side bus of the I2S transceiver: valid/ready DAC sample pairs in and
// strobed ADC sample pairs out. master = sample source/sink, slave = transceiver.
interface i2s_stereo_transceiver_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_left;
  logic [DATA_W-1:0] tx_right;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_left;
  logic [DATA_W-1:0] rx_right;

  modport master (
    output tx_valid, tx_left, tx_right,
    input  tx_ready, rx_valid, rx_left, rx_right
  );

  modport slave (
    input  tx_valid, tx_left, tx_right,
    output tx_ready, rx_valid, rx_left, rx_right
  );

endinterface

// File: rtl/i2s_edge_detect.sv
// Registers the generator's bclk/lrclk levels and the serial input once, and
// derives single-cycle bclk rise/fall and frame-start (lrclk fall) strobes.
module i2s_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdata,
  output logic rise,
  output logic fall,
  output logic fstart,
  output logic sdata_q
);

  logic bclk_q;
  logic lrclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      bclk_q  <= bclk;
      lrclk_q <= lrclk;
      sdata_q <= sdata;
    end
  end

  assign rise   = bclk & ~bclk_q;
  assign fall   = ~bclk & bclk_q;
  assign fstart = lrclk_q & ~lrclk;

endmodule

// File: rtl/i2s_stereo_transceiver.sv
// Stereo I2S data engine (WM8731 I2S format, 1-bit MSB delay) timed by clk-domain
// bclk/lrclk levels. Optional I2S_LOOPBACK_EN adds a loopback port routing dacdat to RX.
module i2s_stereo_transceiver
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  input  logic lrclk,
  input  logic adcdat,
`ifdef I2S_LOOPBACK_EN
  input  logic loopback,
`endif
  output logic dacdat,
  output logic underrun,
  output logic locked,
  i2s_stereo_transceiver_if.slave bus
);

  localparam int FB    = frame_bits(DATA_W);
  localparam int CNT_W = $clog2(FB + 1);
  localparam logic [CNT_W-1:0] FB_CNT = CNT_W'(FB);

  logic serial_in;
  logic rise, fall, fstart, sdata_q;

`ifdef I2S_LOOPBACK_EN
  assign serial_in = loopback ? dacdat : adcdat;
`else
  assign serial_in = adcdat;
`endif

  i2s_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .bclk   (bclk),
    .lrclk  (lrclk),
    .sdata  (serial_in),
    .rise   (rise),
    .fall   (fall),
    .fstart (fstart),
    .sdata_q(sdata_q)
  );

  lock_state_t      state_q, state_d;
  logic             frame_start, shift_en, capture_en;
  logic [FB-1:0]    hold;
  logic             hold_full;
  logic [FB-1:0]    tx_sr;
  logic [FB-2:0]    rx_sr;
  logic [FB-1:0]    rx_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             rx_armed;
  logic             load;
  logic             aligned;

  assign bus.tx_ready = ~hold_full;
  assign load         = bus.tx_valid & ~hold_full;
  assign aligned      = (bit_cnt == FB_CNT);
  assign rx_next      = {rx_sr, sdata_q};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state_q;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    capture_en  = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (fstart) begin
          state_d     = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        frame_start = fstart;
        shift_en    = fall & ~fstart;
        capture_en  = rise;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= UNLOCKED;
      hold         <= '0;
      hold_full    <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      bit_cnt      <= '0;
      rx_armed     <= 1'b0;
      dacdat       <= 1'b0;
      underrun     <= 1'b0;
      locked       <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_left  <= '0;
      bus.rx_right <= '0;
    end else begin
      state_q      <= state_d;
      underrun     <= 1'b0;
      bus.rx_valid <= 1'b0;

      // A pair offered in the frame-start cycle lands in hold, never straight in the shifter.
      if (load) begin
        hold      <= {bus.tx_left, bus.tx_right};
        hold_full <= 1'b1;
      end else if (frame_start && hold_full) begin
        hold_full <= 1'b0;
      end

      if (frame_start) begin
        dacdat   <= tx_sr[FB-1];
        tx_sr    <= hold_full ? hold : '0;
        underrun <= ~hold_full;
        bit_cnt  <= '0;
        locked   <= (state_q == UNLOCKED) | aligned;
        rx_armed <= (state_q == RUN) & aligned;
      end else if (shift_en) begin
        dacdat <= tx_sr[FB-1];
        tx_sr  <= tx_sr << 1;
      end

      // Slot 0 carries the previous right LSB, completing the previous frame's pair.
      if (capture_en) begin
        rx_sr <= rx_next[FB-2:0];
        if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == '0 && rx_armed) begin
          bus.rx_valid <= 1'b1;
          bus.rx_left  <= rx_next[FB-1:DATA_W];
          bus.rx_right <= rx_next[DATA_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_stereo_transceiver.sv
// Directed bench for i2s_stereo_transceiver: bclk/lrclk generator model, I2S codec
// model and per-frame monitors, with one task per scenario.
module tb_i2s_stereo_transceiver;
  import i2s_pkg::*;

  localparam int DW   = DATA_W_DEFAULT;
  localparam int FB   = FRAME_BITS;
  localparam int CYC  = 1536;
  localparam int HALF = 768;
  localparam int NFR  = 64;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic bclk   = 1'b0;
  logic lrclk  = 1'b0;
  logic adcdat = 1'b0;
  logic dacdat, underrun, locked;
`ifdef I2S_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  always #5 clk = ~clk;

  i2s_stereo_transceiver_if #(.DATA_W(DW)) bus ();

  i2s_stereo_transceiver #(.DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .adcdat  (adcdat),
`ifdef I2S_LOOPBACK_EN
    .loopback(loopback),
`endif
    .dacdat  (dacdat),
    .underrun(underrun),
    .locked  (locked),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int            gen_cnt   = 0;
  int            gen_frame = 0;
  logic [FB-1:0] codec_pair = '0;
  logic [FB-1:0] codec_word = '0;
  logic          codec_out  = 1'b0;
  bit            ext_loop   = 1'b0;

  logic [FB-1:0] dac_acc = '0;
  logic [FB-1:0] dac_hist [NFR];
  int            ur_hist  [NFR];
  int            rx_cnt_hist [NFR];
  logic [DW-1:0] rx_l_hist [NFR];
  logic [DW-1:0] rx_r_hist [NFR];

  logic [FB-1:0] str_pair  [16];
  int            str_frame [16];

  // Generator + codec + monitors, all on the falling clk edge.
  initial begin
    for (int i = 0; i < NFR; i++) begin
      ur_hist[i] = 0;
      rx_cnt_hist[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (gen_cnt % 32 == 24) begin
        if (gen_cnt / 32 == 0) begin
          dac_acc[0] = dacdat;
          if (gen_frame > 0 && gen_frame <= NFR) dac_hist[gen_frame-1] = dac_acc;
        end else begin
          dac_acc[FB - gen_cnt / 32] = dacdat;
        end
      end
      if (gen_frame < NFR) begin
        if (bus.rx_valid === 1'b1) begin
          rx_cnt_hist[gen_frame]++;
          rx_l_hist[gen_frame] = bus.rx_left;
          rx_r_hist[gen_frame] = bus.rx_right;
        end
        if (underrun === 1'b1) ur_hist[gen_frame]++;
      end
      gen_cnt = (gen_cnt == CYC - 1) ? 0 : gen_cnt + 1;
      if (gen_cnt == 0) gen_frame++;
      bclk  = (gen_cnt % 32) >= 16;
      lrclk = gen_cnt >= HALF;
      if (gen_cnt % 32 == 0) begin
        if (gen_cnt == 0) begin
          codec_out  = codec_word[0];
          codec_word = codec_pair;
        end else begin
          codec_out = codec_word[FB - gen_cnt / 32];
        end
      end
      adcdat = ext_loop ? dacdat : codec_out;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic sync_frame(output int f);
    f = -1;
    for (int i = 0; i < CYC + 8; i++) begin
      step();
      if (gen_cnt == 100) begin
        f = gen_frame;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL sync_frame: got no frame start, required one within %0d cycles", CYC + 8);
  endtask

  task automatic wait_cnt(input int c);
    for (int i = 0; i < CYC + 8; i++) begin
      step();
      if (gen_cnt == c) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_cnt: got no count %0d, required within %0d cycles", c, CYC + 8);
  endtask

  task automatic push(input logic [FB-1:0] p);
    bus.tx_valid = 1'b1;
    {bus.tx_left, bus.tx_right} = p;
    for (int i = 0; i < 2 * CYC; i++) begin
      if (bus.tx_ready === 1'b1) begin
        step();
        bus.tx_valid = 1'b0;
        return;
      end
      step();
    end
    bus.tx_valid = 1'b0;
    n_checks++; n_fail++;
    $display("FAIL push_timeout: got tx_ready=0 for %0d cycles, required 1", 2 * CYC);
  endtask

  // Holds tx_valid high and presents str_pair[k] until n pairs are accepted.
  task automatic stream(input int n);
    int k = 0;
    bus.tx_valid = 1'b1;
    {bus.tx_left, bus.tx_right} = str_pair[0];
    for (int i = 0; i < (n + 2) * CYC && k < n; i++) begin
      if (bus.tx_ready === 1'b1) begin
        str_frame[k] = gen_frame;
        k++;
        step();
        if (k < n) {bus.tx_left, bus.tx_right} = str_pair[k];
      end else begin
        step();
      end
    end
    bus.tx_valid = 1'b0;
    if (k < n) begin
      n_checks++; n_fail++;
      $display("FAIL stream_timeout: got %0d pairs accepted, required %0d", k, n);
    end
  endtask

  task automatic test_reset();
    int f;
    rst = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_left  = '0;
    bus.tx_right = '0;
    repeat (4) step();
    n_checks++; if (dacdat !== 1'b0)       begin n_fail++; $display("FAIL reset_dacdat: got %b required 0", dacdat); end
    n_checks++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b required 1", bus.tx_ready); end
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b required 0", bus.rx_valid); end
    n_checks++; if (bus.rx_left !== '0)    begin n_fail++; $display("FAIL reset_rx_left: got %h required 0", bus.rx_left); end
    n_checks++; if (bus.rx_right !== '0)   begin n_fail++; $display("FAIL reset_rx_right: got %h required 0", bus.rx_right); end
    n_checks++; if (underrun !== 1'b0)     begin n_fail++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    n_checks++; if (locked !== 1'b0)       begin n_fail++; $display("FAIL reset_locked: got %b required 0", locked); end
    rst = 1'b0;
    wait_cnt(1000);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL prelock_locked: got %b required 0", locked); end
    sync_frame(f);
    n_checks++; if (locked !== 1'b1)  begin n_fail++; $display("FAIL lock_locked: got %b required 1", locked); end
    n_checks++; if (ur_hist[f] !== 1) begin n_fail++; $display("FAIL lock_underrun: got %0d required 1", ur_hist[f]); end
    n_checks++; if (rx_cnt_hist[f] !== 0) begin n_fail++; $display("FAIL lock_rx_valid: got %0d strobes required 0", rx_cnt_hist[f]); end
  endtask

  task automatic test_tx();
    int f, g;
    sync_frame(f);
    push({24'h800001, 24'h7FFFFE});
    n_checks++; if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_hold_full: got tx_ready=%b required 0", bus.tx_ready); end
    sync_frame(g);
    n_checks++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_hold_freed: got tx_ready=%b required 1", bus.tx_ready); end
    n_checks++; if (ur_hist[f+1] !== 0)    begin n_fail++; $display("FAIL tx_no_underrun: got %0d required 0", ur_hist[f+1]); end
    sync_frame(g);
    n_checks++;
    if (dac_hist[f+1] !== {24'h800001, 24'h7FFFFE}) begin
      n_fail++; $display("FAIL tx_dac_word: got %h required %h", dac_hist[f+1], {24'h800001, 24'h7FFFFE});
    end
  endtask

  task automatic test_rx();
    int f, g;
    sync_frame(f);
    codec_pair = {24'h123456, 24'hABCDEF};
    sync_frame(g);
    sync_frame(g);
    n_checks++; if (rx_cnt_hist[f+1] !== 1) begin n_fail++; $display("FAIL rx_prev_strobe: got %0d required 1", rx_cnt_hist[f+1]); end
    n_checks++; if (rx_l_hist[f+1] !== '0)  begin n_fail++; $display("FAIL rx_prev_left: got %h required 0", rx_l_hist[f+1]); end
    n_checks++; if (rx_cnt_hist[f+2] !== 1) begin n_fail++; $display("FAIL rx_strobe: got %0d required 1", rx_cnt_hist[f+2]); end
    n_checks++; if (rx_l_hist[f+2] !== 24'h123456) begin n_fail++; $display("FAIL rx_left: got %h required 123456", rx_l_hist[f+2]); end
    n_checks++; if (rx_r_hist[f+2] !== 24'hABCDEF) begin n_fail++; $display("FAIL rx_right: got %h required abcdef", rx_r_hist[f+2]); end
    n_checks++; if (bus.rx_left !== 24'h123456)    begin n_fail++; $display("FAIL rx_left_held: got %h required 123456", bus.rx_left); end
  endtask

  task automatic test_underrun();
    int f, g;
    sync_frame(f);
    for (int i = 1; i <= 3; i++) begin
      sync_frame(g);
      n_checks++; if (ur_hist[f+i] !== 1)    begin n_fail++; $display("FAIL underrun_strobe_%0d: got %0d required 1", i, ur_hist[f+i]); end
      n_checks++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL underrun_ready_%0d: got %b required 1", i, bus.tx_ready); end
    end
    n_checks++; if (dac_hist[f+1] !== '0) begin n_fail++; $display("FAIL underrun_dac_1: got %h required 0", dac_hist[f+1]); end
    n_checks++; if (dac_hist[f+2] !== '0) begin n_fail++; $display("FAIL underrun_dac_2: got %h required 0", dac_hist[f+2]); end
  endtask

  task automatic test_back_to_back();
    int f, g;
    str_pair[0] = {24'hA5A5A5, 24'h000001};
    str_pair[1] = {24'h000001, 24'hFFFFFF};
    str_pair[2] = {24'h7FFFFF, 24'h800000};
    str_pair[3] = {24'hFFFFFF, 24'h000000};
    sync_frame(f);
    stream(4);
    for (int i = 0; i < 6; i++) sync_frame(g);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (str_frame[k] !== f + k) begin n_fail++; $display("FAIL b2b_accept_%0d: got frame %0d required %0d", k, str_frame[k], f + k); end
      n_checks++; if (dac_hist[f+1+k] !== str_pair[k]) begin n_fail++; $display("FAIL b2b_dac_%0d: got %h required %h", k, dac_hist[f+1+k], str_pair[k]); end
      n_checks++; if (ur_hist[f+1+k] !== 0) begin n_fail++; $display("FAIL b2b_underrun_%0d: got %0d required 0", k, ur_hist[f+1+k]); end
    end
  endtask

  task automatic test_reset_mid();
    int f, g;
    sync_frame(f);
    codec_pair = {24'h5A5A5A, 24'h00FF00};
    push({24'h111111, 24'h222222});
    wait_cnt(700);
    rst = 1'b1;
    repeat (3) step();
    n_checks++; if (locked !== 1'b0)       begin n_fail++; $display("FAIL rstmid_locked: got %b required 0", locked); end
    n_checks++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_ready: got %b required 1", bus.tx_ready); end
    n_checks++; if (dacdat !== 1'b0)       begin n_fail++; $display("FAIL rstmid_dacdat: got %b required 0", dacdat); end
    n_checks++; if (bus.rx_left !== '0)    begin n_fail++; $display("FAIL rstmid_rx_left: got %h required 0", bus.rx_left); end
    n_checks++; if (bus.rx_right !== '0)   begin n_fail++; $display("FAIL rstmid_rx_right: got %h required 0", bus.rx_right); end
    rst = 1'b0;
    wait_cnt(1500);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rstmid_prelock: got %b required 0", locked); end
    n_checks++; if (dacdat !== 1'b0) begin n_fail++; $display("FAIL rstmid_dac_idle: got %b required 0", dacdat); end
    sync_frame(g);
    n_checks++; if (locked !== 1'b1)        begin n_fail++; $display("FAIL rstmid_relock: got %b required 1", locked); end
    n_checks++; if (ur_hist[f+1] !== 1)     begin n_fail++; $display("FAIL rstmid_underrun: got %0d required 1", ur_hist[f+1]); end
    n_checks++; if (rx_cnt_hist[f+1] !== 0) begin n_fail++; $display("FAIL rstmid_rx_dropped: got %0d required 0", rx_cnt_hist[f+1]); end
    sync_frame(g);
    n_checks++; if (rx_cnt_hist[f+2] !== 1)        begin n_fail++; $display("FAIL rstmid_rx_strobe: got %0d required 1", rx_cnt_hist[f+2]); end
    n_checks++; if (rx_l_hist[f+2] !== 24'h5A5A5A) begin n_fail++; $display("FAIL rstmid_rx_left: got %h required 5a5a5a", rx_l_hist[f+2]); end
    n_checks++; if (rx_r_hist[f+2] !== 24'h00FF00) begin n_fail++; $display("FAIL rstmid_rx_right: got %h required 00ff00", rx_r_hist[f+2]); end
  endtask

  task automatic test_loopback();
    int f, g;
    localparam int N = 12;
`ifdef I2S_LOOPBACK_EN
    loopback = 1'b1;
`else
    ext_loop = 1'b1;
`endif
    for (int k = 0; k < N; k++) str_pair[k] = {24'($urandom), 24'($urandom)};
    sync_frame(f);
    stream(N);
    wait_cnt(0);
    wait_cnt(0);
    wait_cnt(200);
    for (int k = 0; k < N; k++) begin
      g = str_frame[k] + 2;
      if (g >= NFR) g = NFR - 1;
      n_checks++;
      if (rx_cnt_hist[g] !== 1 || {rx_l_hist[g], rx_r_hist[g]} !== str_pair[k]) begin
        n_fail++;
        $display("FAIL loopback_%0d: got %0d strobes pair %h required 1 strobe pair %h",
                 k, rx_cnt_hist[g], {rx_l_hist[g], rx_r_hist[g]}, str_pair[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
